// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: STAGES carry slices, one beat per
// cycle, valid/ready on both sides, global stall when the output is blocked.
module pipelined_add_sub #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned SLICE = WIDTH / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   // Per-stage registers: valid, slice carry-out, skewed operands, partial result
   logic             v_q  [STAGES];
   logic             c_q  [STAGES];
   logic [WIDTH-1:0] a_q  [STAGES];
   logic [WIDTH-1:0] b_q  [STAGES];
   logic [WIDTH-1:0] r_q  [STAGES];
   logic             ovf_q;
   logic             zero_q;
   logic             rdy_q;

   // Per-stage combinational inputs and results
   logic             v_s   [STAGES];
   logic             ci_s  [STAGES];
   logic [WIDTH-1:0] a_s   [STAGES];
   logic [WIDTH-1:0] b_s   [STAGES];
   logic [WIDTH-1:0] r_s   [STAGES];
   logic [WIDTH-1:0] r_d   [STAGES];
   logic [SLICE:0]   slc_s [STAGES];

   logic en;
   logic cmsb;
   logic ovf_d;
   logic zero_d;
   logic unused_ops;

   assign en       = !(v_q[LAST] && !out_ready);
   assign in_ready = rdy_q && en;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_first
            assign v_s[k]  = in_valid && in_ready;
            assign a_s[k]  = a;
            assign b_s[k]  = sub ? ~b : b;
            assign ci_s[k] = sub | cin;
            assign r_s[k]  = '0;
         end else begin : g_next
            assign v_s[k]  = v_q[k-1];
            assign a_s[k]  = a_q[k-1];
            assign b_s[k]  = b_q[k-1];
            assign ci_s[k] = c_q[k-1];
            assign r_s[k]  = r_q[k-1];
         end
         assign slc_s[k] = {1'b0, a_s[k][k*SLICE +: SLICE]}
                         + {1'b0, b_s[k][k*SLICE +: SLICE]}
                         + {{SLICE{1'b0}}, ci_s[k]};
         // Slices above k are still zero, so OR-ing in the new slice is exact
         assign r_d[k] = r_s[k] | (WIDTH'(slc_s[k][SLICE-1:0]) << (k*SLICE));
      end
   endgenerate

   // Carry into the MSB recovered from the MSB sum bit and its operand bits
   assign cmsb   = a_s[LAST][WIDTH-1] ^ b_s[LAST][WIDTH-1] ^ r_d[LAST][WIDTH-1];
   assign ovf_d  = cmsb ^ slc_s[LAST][SLICE];
   assign zero_d = (r_d[LAST] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q  <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int unsigned i = 0; i < STAGES; i++) begin
            v_q[i] <= 1'b0;
            c_q[i] <= 1'b0;
            a_q[i] <= '0;
            b_q[i] <= '0;
            r_q[i] <= '0;
         end
      end else begin
         rdy_q <= 1'b1;
         if (en) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            for (int unsigned i = 0; i < STAGES; i++) begin
               v_q[i] <= v_s[i];
               c_q[i] <= slc_s[i][SLICE];
               a_q[i] <= a_s[i];
               b_q[i] <= b_s[i];
               r_q[i] <= r_d[i];
            end
         end
      end
   end

   always_comb begin
      unused_ops = 1'b0;
      for (int unsigned i = 0; i < STAGES; i++) begin
         unused_ops = unused_ops ^ (^a_q[i]) ^ (^b_q[i]);
      end
   end

   assign out_valid = v_q[LAST];
   assign sum       = r_q[LAST];
   assign cout      = c_q[LAST];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Scoreboard bench for pipelined_add_sub: 32/4 main instance plus 8/2 and 16/1
// instances, all checked against a signed/unsigned arithmetic reference model.
module tb_pipelined_add_sub;

   localparam int W0 = 32, S0 = 4;
   localparam int W1 = 8,  S1 = 2;
   localparam int W2 = 16, S2 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, rst2_n;

   logic        m_iv, m_ir, m_cin, m_sub, m_ov, m_or, m_cout, m_ovf, m_zero;
   logic [31:0] m_a, m_b, m_sum;

   logic        x_iv, x_cin, x_sub, x_or;
   logic [15:0] x_a, x_b;
   logic        b_ir, b_ov, b_cout, b_ovf, b_zero;
   logic [7:0]  b_sum;
   logic        c_ir, c_ov, c_cout, c_ovf, c_zero;
   logic [15:0] c_sum;

   pipelined_add_sub #(.WIDTH(W0), .STAGES(S0)) dut_m (
      .clk(clk), .rst_n(rst_n), .in_valid(m_iv), .in_ready(m_ir),
      .a(m_a), .b(m_b), .cin(m_cin), .sub(m_sub),
      .out_valid(m_ov), .out_ready(m_or), .sum(m_sum),
      .cout(m_cout), .overflow(m_ovf), .zero(m_zero));

   pipelined_add_sub #(.WIDTH(W1), .STAGES(S1)) dut_b (
      .clk(clk), .rst_n(rst2_n), .in_valid(x_iv), .in_ready(b_ir),
      .a(x_a[7:0]), .b(x_b[7:0]), .cin(x_cin), .sub(x_sub),
      .out_valid(b_ov), .out_ready(x_or), .sum(b_sum),
      .cout(b_cout), .overflow(b_ovf), .zero(b_zero));

   pipelined_add_sub #(.WIDTH(W2), .STAGES(S2)) dut_c (
      .clk(clk), .rst_n(rst2_n), .in_valid(x_iv), .in_ready(c_ir),
      .a(x_a), .b(x_b), .cin(x_cin), .sub(x_sub),
      .out_valid(c_ov), .out_ready(x_or), .sum(c_sum),
      .cout(c_cout), .overflow(c_ovf), .zero(c_zero));

   typedef struct {
      logic [31:0] sum;
      bit          cout;
      bit          ovf;
      bit          zero;
      int          acc;
      bit          lat;
   } exp_t;

   exp_t qm[$], qb[$], qc[$];
   exp_t em, eb, ec;
   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   bit   lat_chk = 1'b1;
   bit   bc_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Reference: unsigned sum modulo 2^w, borrow/carry from magnitudes, overflow
   // from whether the exact signed result fits in w bits.
   function automatic exp_t model(input int w, input longint ua0, input longint ub0,
                                  input bit cin, input bit sub);
      exp_t   e;
      longint one, mask, half, ua, ub, sa, sb, full, sres;
      one  = 1;
      mask = (one << w) - 1;
      half = one << (w - 1);
      ua   = ua0 & mask;
      ub   = ub0 & mask;
      sa   = (ua >= half) ? ua - (one << w) : ua;
      sb   = (ub >= half) ? ub - (one << w) : ub;
      if (sub) begin
         full   = ua - ub;
         sres   = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         full   = ua + ub + longint'(cin);
         sres   = sa + sb + longint'(cin);
         e.cout = (full > mask);
      end
      e.sum  = 32'(full & mask);
      e.ovf  = (sres > half - 1) || (sres < -half);
      e.zero = ((full & mask) == 0);
      e.acc  = 0;
      e.lat  = 1'b0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && m_ov && m_or) begin
         if (qm.size() == 0) fail_now("m_unexpected_out");
         else begin
            em = qm.pop_front();
            chk("m_sum",  64'(m_sum),  64'(em.sum));
            chk("m_cout", 64'(m_cout), 64'(em.cout));
            chk("m_ovf",  64'(m_ovf),  64'(em.ovf));
            chk("m_zero", 64'(m_zero), 64'(em.zero));
            if (em.lat) chk("m_latency", 64'(cyc - em.acc), 64'(S0));
         end
      end
   end

   always @(negedge clk) begin
      if (rst2_n && b_ov && x_or) begin
         if (qb.size() == 0) fail_now("b_unexpected_out");
         else begin
            eb = qb.pop_front();
            chk("b_sum",     64'(b_sum),  64'(eb.sum));
            chk("b_cout",    64'(b_cout), 64'(eb.cout));
            chk("b_ovf",     64'(b_ovf),  64'(eb.ovf));
            chk("b_zero",    64'(b_zero), 64'(eb.zero));
            chk("b_latency", 64'(cyc - eb.acc), 64'(S1));
         end
      end
   end

   always @(negedge clk) begin
      if (rst2_n && c_ov && x_or) begin
         if (qc.size() == 0) fail_now("c_unexpected_out");
         else begin
            ec = qc.pop_front();
            chk("c_sum",     64'(c_sum),  64'(ec.sum));
            chk("c_cout",    64'(c_cout), 64'(ec.cout));
            chk("c_ovf",     64'(c_ovf),  64'(ec.ovf));
            chk("c_zero",    64'(c_zero), 64'(ec.zero));
            chk("c_latency", 64'(cyc - ec.acc), 64'(S2));
         end
      end
   end

   // Called just after a posedge; returns just after the posedge that accepts.
   task automatic m_send(input logic [31:0] a, input logic [31:0] b, input bit cin, input bit sub);
      bit   done;
      exp_t e;
      done  = 1'b0;
      m_iv  = 1'b1;
      m_a   = a;
      m_b   = b;
      m_cin = cin;
      m_sub = sub;
      for (int t = 0; t < 100 && !done; t++) begin
         @(negedge clk);
         if (m_ir) begin
            e     = model(W0, 64'(a), 64'(b), cin, sub);
            e.acc = cyc;
            e.lat = lat_chk;
            qm.push_back(e);
            done  = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      m_iv = 1'b0;
      if (!done) fail_now("m_send_timeout");
   endtask

   task automatic m_rand();
      m_send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic m_drain();
      int t;
      t = 0;
      while (qm.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (qm.size() != 0) fail_now("m_drain");
      #1;
   endtask

   // Secondary instances: directed corners then random beats with bubbles
   logic [15:0] da [6] = '{16'h00FF, 16'h007F, 16'h0080, 16'h0005, 16'h0007, 16'hFFFF};
   logic [15:0] db [6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h0001};
   bit          dc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   bit          ds [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   initial begin : bc_stim
      exp_t e;
      int   t;
      x_iv = 1'b0; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0; x_or = 1'b1;
      wait (rst2_n === 1'b1);
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 300; i++) begin
         if (i < 6) begin
            x_iv = 1'b1; x_a = da[i]; x_b = db[i]; x_cin = dc[i]; x_sub = ds[i];
         end else begin
            x_iv  = ($urandom_range(0, 3) != 0);
            x_a   = 16'($urandom);
            x_b   = 16'($urandom);
            x_cin = 1'($urandom_range(0, 1));
            x_sub = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         if (x_iv) begin
            chk("b_in_ready", 64'(b_ir), 64'(1));
            chk("c_in_ready", 64'(c_ir), 64'(1));
            e = model(W1, 64'(x_a), 64'(x_b), x_cin, x_sub);
            e.acc = cyc; e.lat = 1'b1;
            qb.push_back(e);
            e = model(W2, 64'(x_a), 64'(x_b), x_cin, x_sub);
            e.acc = cyc; e.lat = 1'b1;
            qc.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      x_iv = 1'b0;
      t = 0;
      while ((qb.size() != 0 || qc.size() != 0) && t < 50) begin
         @(posedge clk);
         t++;
      end
      if (qb.size() != 0 || qc.size() != 0) fail_now("bc_drain");
      bc_done = 1'b1;
   end

   initial begin : main_stim
      logic [31:0] s_sum;
      logic        s_cout, s_ovf, s_zero;
      rst_n = 1'b0; rst2_n = 1'b0;
      m_iv = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_or = 1'b1;

      #12;
      chk("rst_out_valid", 64'(m_ov),   64'(0));
      chk("rst_sum",       64'(m_sum),  64'(0));
      chk("rst_cout",      64'(m_cout), 64'(0));
      chk("rst_ovf",       64'(m_ovf),  64'(0));
      chk("rst_zero",      64'(m_zero), 64'(0));
      #10;
      rst_n = 1'b1; rst2_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", 64'(m_ir), 64'(1));

      // Directed corners
      m_send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      m_send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
      m_send(32'h0000_FFFF, 32'h1, 1'b0, 1'b0);
      m_send(32'h5,         32'h7, 1'b1, 1'b1);
      m_send(32'h7,         32'h7, 1'b0, 1'b1);
      m_send(32'h8000_0000, 32'h1, 1'b0, 1'b1);
      m_send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      m_drain();

      // Back-to-back throughput
      for (int i = 0; i < 10; i++) m_rand();
      m_drain();

      // Backpressure with beats in flight and a beat waiting at the input
      lat_chk = 1'b0;
      for (int i = 0; i < 6; i++) m_rand();
      m_or = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (m_ov) break;
      end
      if (!m_ov) fail_now("stall_wait");
      s_sum = m_sum; s_cout = m_cout; s_ovf = m_ovf; s_zero = m_zero;
      @(posedge clk);
      #1;
      fork
         begin
            repeat (5) begin
               @(negedge clk);
               chk("stall_in_ready",  64'(m_ir),   64'(0));
               chk("stall_out_valid", 64'(m_ov),   64'(1));
               chk("stall_sum",       64'(m_sum),  64'(s_sum));
               chk("stall_flags",     64'({m_cout, m_ovf, m_zero}), 64'({s_cout, s_ovf, s_zero}));
            end
            @(posedge clk);
            #1;
            m_or = 1'b1;
         end
         m_rand();
      join
      m_drain();

      // Random backpressure and input bubbles
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               @(posedge clk);
               #1;
               m_or = ($urandom_range(0, 2) != 0);
            end
            m_or = 1'b1;
         end
         begin
            for (int i = 0; i < 30; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
               m_rand();
            end
         end
      join
      m_or = 1'b1;
      m_drain();

      // Asynchronous reset with beats in flight
      lat_chk = 1'b1;
      for (int i = 0; i < 5; i++) m_rand();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(m_ov),   64'(0));
      chk("midrst_sum",       64'(m_sum),  64'(0));
      chk("midrst_flags",     64'({m_cout, m_ovf, m_zero}), 64'(0));
      qm.delete();
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_midrst", 64'(m_ir), 64'(1));
      m_send(32'h2, 32'h3, 1'b0, 1'b0);
      m_drain();
      repeat (10) @(posedge clk);

      for (int t = 0; t < 3000 && !bc_done; t++) @(posedge clk);
      if (!bc_done) fail_now("bc_done_wait");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
